// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between wb_burst_master (initiator) and a slave.
// Signal suffixes are from the initiator's point of view.
interface wb_burst_master_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        ack_i;
  logic        err_i;

  modport master (
    output adr_o, dat_o, we_o, stb_o, cyc_o, sel_o, cti_o, bte_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, stb_o, cyc_o, sel_o, cti_o, bte_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator: single read/write cycles and linear line-fill read bursts,
// with a per-beat watchdog so every accepted request terminates.
module wb_burst_master #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic        req_burst_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rd_dat_o,
  output logic        rd_valid_o,
  output logic [3:0]  rd_idx_o,
  wb_burst_master_if.master wb
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSingle = 2'd1;
  localparam logic [1:0] StBurst  = 2'd2;

  localparam logic [3:0]  LastBeat = 4'(LINE_WORDS - 1);
  localparam logic [15:0] WdLast   = 16'(TIMEOUT - 1);
  // Clears the byte offset within a cache line.
  localparam logic [31:0] LineMask = ~32'(LINE_WORDS * 4 - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [15:0] wd_q, wd_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0] rd_dat_q, rd_dat_d;
  logic        rd_valid_q, rd_valid_d;
  logic [3:0]  rd_idx_q, rd_idx_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        we_q, we_d, cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  cti_q, cti_d;
  logic        abort;

  // Error and watchdog expiry share one termination path; err_i beats ack_i.
  assign abort = wb.err_i || (!wb.ack_i && (wd_q == WdLast));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wd_d       = wd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_dat_d   = rd_dat_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    sel_d      = sel_q;
    cti_d      = cti_q;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          busy_d = 1'b1;
          cyc_d  = 1'b1;
          wd_d   = '0;
          beat_d = '0;
          if (req_burst_i) begin
            state_d = StBurst;
            adr_d   = req_adr_i & LineMask;
            sel_d   = 4'hF;
            we_d    = 1'b0;
            cti_d   = 3'b010;
          end else begin
            state_d = StSingle;
            adr_d   = {req_adr_i[31:2], 2'b00};
            we_d    = req_we_i;
            dat_d   = req_dat_i;
            sel_d   = req_sel_i;
            cti_d   = 3'b111;
          end
        end
      end
      StSingle, StBurst: begin
        if (abort || (wb.ack_i && (state_q == StSingle || beat_q == LastBeat))) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = abort;
        end
        if (abort) begin
          wd_d = wd_q;
        end else if (wb.ack_i) begin
          wd_d = '0;
          if (state_q == StBurst) begin
            rd_dat_d   = wb.dat_i;
            rd_valid_d = 1'b1;
            rd_idx_d   = beat_q;
            if (beat_q != LastBeat) begin
              adr_d  = adr_q + 32'd4;
              beat_d = beat_q + 4'd1;
              cti_d  = (beat_q + 4'd1 == LastBeat) ? 3'b111 : 3'b010;
            end
          end else if (!we_q) begin
            rd_dat_d   = wb.dat_i;
            rd_valid_d = 1'b1;
            rd_idx_d   = 4'd0;
          end
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      sel_q      <= '0;
      cti_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_dat_q   <= rd_dat_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rd_dat_o   = rd_dat_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_idx_o   = rd_idx_q;
  assign wb.adr_o   = adr_q;
  assign wb.dat_o   = dat_q;
  assign wb.we_o    = we_q;
  assign wb.stb_o   = cyc_q;
  assign wb.cyc_o   = cyc_q;
  assign wb.sel_o   = sel_q;
  assign wb.cti_o   = cti_q;
  assign wb.bte_o   = 2'b00;

endmodule

// File: tb/tb_wb_burst_master.sv
// Cycle-by-cycle vector bench for wb_burst_master (LINE_WORDS=4, TIMEOUT=8),
// plus hand-written timeout and mid-burst reset sequences.
module tb_wb_burst_master;

  localparam logic [31:0] WrData = 32'h1234_5678;

  logic        clk;
  logic        rst;
  logic        req, req_we, req_burst;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        busy, done, err;
  logic [31:0] rd_dat;
  logic        rd_valid;
  logic [3:0]  rd_idx;

  int checks = 0;
  int errors = 0;

  wb_burst_master_if bus ();

  wb_burst_master #(
    .LINE_WORDS (4),
    .TIMEOUT    (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_we_i    (req_we),
    .req_burst_i (req_burst),
    .req_adr_i   (req_adr),
    .req_dat_i   (req_dat),
    .req_sel_i   (req_sel),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .rd_dat_o    (rd_dat),
    .rd_valid_o  (rd_valid),
    .rd_idx_o    (rd_idx),
    .wb          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst, req, we, burst}; ae = {ack, err}; flags = {busy, done, err, rd_valid, cyc, we}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [1:0]  ae;
    logic [31:0] dati;
    logic [5:0]  flags;
    logic [3:0]  ridx;
    logic [31:0] eadr;
    logic [3:0]  esel;
    logic [2:0]  ecti;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] ctl, input logic [31:0] adr,
                              input logic [3:0] sel, input logic [1:0] ae,
                              input logic [31:0] dati, input logic [5:0] flags,
                              input logic [3:0] ridx, input logic [31:0] eadr,
                              input logic [3:0] esel, input logic [2:0] ecti);
    vec_t v;
    v.ctl = ctl; v.adr = adr; v.sel = sel; v.ae = ae; v.dati = dati;
    v.flags = flags; v.ridx = ridx; v.eadr = eadr; v.esel = esel; v.ecti = ecti;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic done_seen;
    logic err_seen;
    int   n;

    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_burst = 1'b0;
    req_adr = '0; req_dat = WrData; req_sel = '0;
    bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = '0;

    // Reset and idle
    add(4'b1000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b000000, 4'd0, 32'h0,   4'h0, 3'b000);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b000000, 4'd0, 32'h0,   4'h0, 3'b000);
    // Single read at 0x103; a burst request while busy must be ignored
    add(4'b0100, 32'h103, 4'hF, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h100, 4'hF, 3'b111);
    add(4'b0101, 32'h80,  4'hF, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h100, 4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'hDEADBEEF,  6'b010100, 4'd0, 32'h100, 4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b000000, 4'd0, 32'h100, 4'hF, 3'b111);
    // Single write with two wait states
    add(4'b0110, 32'h20,  4'h3, 2'b00, 32'h0,         6'b100011, 4'd0, 32'h20,  4'h3, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100011, 4'd0, 32'h20,  4'h3, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100011, 4'd0, 32'h20,  4'h3, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h0,         6'b010000, 4'd0, 32'h20,  4'h3, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b000000, 4'd0, 32'h20,  4'h3, 3'b111);
    // Zero-wait burst from 0x4C; trailing ack with cyc low is ignored
    add(4'b0101, 32'h4C,  4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h40,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h40,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h1111_0000, 6'b100110, 4'd0, 32'h44,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h1111_0001, 6'b100110, 4'd1, 32'h48,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h1111_0002, 6'b100110, 4'd2, 32'h4C,  4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h1111_0003, 6'b010100, 4'd3, 32'h4C,  4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h0,         6'b000000, 4'd0, 32'h4C,  4'hF, 3'b111);
    // Burst with a 3-cycle stall after the first beat
    add(4'b0101, 32'h44,  4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h40,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h40,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h2222_0000, 6'b100110, 4'd0, 32'h44,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h44,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h44,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h44,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h2222_0001, 6'b100110, 4'd1, 32'h48,  4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h2222_0002, 6'b100110, 4'd2, 32'h4C,  4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h2222_0003, 6'b010100, 4'd3, 32'h4C,  4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b000000, 4'd0, 32'h4C,  4'hF, 3'b111);
    // Burst killed by err_i (with ack_i) on beat 2, then a request in the done cycle
    add(4'b0101, 32'h100, 4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h100, 4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h100, 4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h3333_0000, 6'b100110, 4'd0, 32'h104, 4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h3333_0001, 6'b100110, 4'd1, 32'h108, 4'hF, 3'b010);
    add(4'b0000, 32'h0,   4'h0, 2'b11, 32'h3333_0002, 6'b011000, 4'd0, 32'h108, 4'hF, 3'b010);
    add(4'b0100, 32'h200, 4'hF, 2'b00, 32'h0,         6'b100010, 4'd0, 32'h200, 4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b10, 32'h0000_0055, 6'b010100, 4'd0, 32'h200, 4'hF, 3'b111);
    add(4'b0000, 32'h0,   4'h0, 2'b00, 32'h0,         6'b000000, 4'd0, 32'h200, 4'hF, 3'b111);

    foreach (vecs[i]) begin
      @(negedge clk);
      {rst, req, req_we, req_burst} = vecs[i].ctl;
      req_adr   = vecs[i].adr;
      req_sel   = vecs[i].sel;
      {bus.ack_i, bus.err_i} = vecs[i].ae;
      bus.dat_i = vecs[i].dati;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_ctl", i),
            {busy, done, err, rd_valid, bus.cyc_o, bus.stb_o, bus.we_o,
             bus.adr_o, bus.sel_o, bus.cti_o, bus.bte_o},
            {vecs[i].flags[5:1], vecs[i].flags[1], vecs[i].flags[0],
             vecs[i].eadr, vecs[i].esel, vecs[i].ecti, 2'b00});
      if (vecs[i].flags[2])
        check($sformatf("row%0d_rdata", i), {rd_idx, rd_dat}, {vecs[i].ridx, vecs[i].dati});
      if (vecs[i].flags[0])
        check($sformatf("row%0d_wdata", i), bus.dat_o, WrData);
    end

    // Watchdog: no termination from the slave, abort 8 cycles after stb rises
    @(negedge clk);
    rst = 1'b0; req = 1'b1; req_we = 1'b0; req_burst = 1'b0; req_adr = 32'h300; req_sel = 4'hF;
    bus.ack_i = 1'b0; bus.err_i = 1'b0;
    @(posedge clk);
    #1;
    check("to_stb_rise", bus.stb_o, 1'b1);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    done_seen = 1'b0;
    err_seen = 1'b0;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        done_seen = 1'b1;
        err_seen = err;
      end
    end
    check("to_cycles", n, 8);
    check("to_err", {done_seen, err_seen, bus.cyc_o, rd_valid}, 4'b1100);

    // Reset during beat 1 of a burst: everything clears, no done pulse
    @(negedge clk);
    req = 1'b1; req_burst = 1'b1; req_adr = 32'h0;
    @(negedge clk);
    req = 1'b0; req_burst = 1'b0; bus.ack_i = 1'b1; bus.dat_i = 32'h4444_0000;
    @(posedge clk);
    #1;
    check("rst_beat0", {rd_valid, rd_idx, rd_dat, bus.cyc_o}, {1'b1, 4'd0, 32'h4444_0000, 1'b1});
    @(negedge clk);
    bus.ack_i = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_clear",
          {busy, done, err, rd_valid, rd_idx, rd_dat, bus.cyc_o, bus.stb_o, bus.we_o,
           bus.adr_o, bus.dat_o, bus.sel_o, bus.cti_o, bus.bte_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | done | busy | bus.cyc_o;
    end
    check("rst_no_done", done_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Wishbone B3 initiator used by a core or cache to reach on-chip memory and peripheral slaves. It takes a one-cycle request from the core and runs either a single read/write cycle or a linear incrementing read burst that fills a cache line. Returned words stream back to the requester with a beat index. A per-beat watchdog and err_i handling guarantee that every accepted request completes.

Parameters:
LINE_WORDS, 4, words per burst read; power of two, 2..16
TIMEOUT, 255, max cycles with stb_o high and no ack_i/err_i before abort; 1..65535

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  request strobe; sampled only while busy_o=0
req_we_i  in  1  1=single write, 0=read
req_burst_i  in  1  1=line burst read; forces read, req_we_i ignored
req_adr_i  in  32  byte address
req_dat_i  in  32  write data
req_sel_i  in  4  byte selects for single cycles
busy_o  out  1  request in progress
done_o  out  1  one-cycle pulse at completion
err_o  out  1  one-cycle pulse with done_o on error or timeout
rd_dat_o  out  32  returned read word
rd_valid_o  out  1  one-cycle pulse per returned word
rd_idx_o  out  4  beat index of rd_dat_o
adr_o  out  32  WB address, bits [1:0] always 0
dat_o  out  32  WB write data
dat_i  in  32  WB read data
we_o, stb_o, cyc_o  out  1  WB controls
sel_o  out  4  WB byte selects
cti_o  out  3  000 classic-equivalent unused; 010 incrementing; 111 end-of-burst
bte_o  out  2  always 00 (linear)
ack_i, err_i  in  1  WB termination

Behaviour:
- Reset: clk_i posedge with rst_i=1 clears every output to 0, counters to 0, state to IDLE. Reset mid-cycle drops cyc_o/stb_o at that edge; no done_o pulse for the aborted request.
- All outputs are registered.
- States: IDLE, SINGLE, BURST.
- IDLE: on req_i=1, latch the request and go to SINGLE or BURST. busy_o, cyc_o and stb_o rise on the same edge, one cycle after req_i.
- req_i is ignored while busy_o=1.
- SINGLE: adr_o={req_adr_i[31:2],2'b00}; we_o=req_we_i; dat_o=req_dat_i; sel_o=req_sel_i; cti_o=111.
- SINGLE, edge with ack_i=1: drop cyc/stb/we. Pulse done_o. For reads, also rd_dat_o=dat_i, rd_valid_o=1, rd_idx_o=0. Return to IDLE.
- BURST start: adr_o = req_adr_i with bits [log2(LINE_WORDS)+1:0] cleared; sel_o=1111; we_o=0. cti_o=010, or 111 when beat count is LINE_WORDS-1.
- BURST, each ack_i edge: rd_dat_o=dat_i; rd_valid_o=1; rd_idx_o=beat; adr_o+=4; beat+=1. cti_o becomes 111 for the final beat.
- BURST, ack on the final beat: drop cyc/stb, pulse done_o, return to IDLE.
- BURST address does not wrap inside the line: the start is aligned and the burst is linear.
- Wait states (ack_i=0, err_i=0): all WB outputs hold.
- Zero-wait slave (ack one cycle after stb, then held continuously): LINE_WORDS beats complete in LINE_WORDS+1 cycles from cyc_o rise.
- err_i=1 while stb_o=1: terminate at that edge, pulse err_o and done_o, no rd_valid_o for that beat.
- err_i and ack_i both high: err_i wins.
- Watchdog: counter clears on cycle start and on every ack_i. It increments while stb_o=1 and ack_i=0.
- Watchdog reaching TIMEOUT: terminate exactly as for err_i.
- ack_i/err_i while cyc_o=0: ignored.
- busy_o falls on the same edge done_o rises. A new req_i is accepted in the done_o cycle.
- rd_valid_o, done_o and err_o are never high for more than one consecutive cycle per event.

Test Plan:
- Single read, addr 0x0000_0103, slave acks 1 cycle after stb with dat_i=0xDEADBEEF -> adr_o=0x100, cti_o=111. Next cycle: rd_valid_o=1, rd_dat_o=0xDEADBEEF, done_o=1.
- Single write, addr 0x20, data 0x12345678, sel 0011 -> we_o=1, sel_o=0011, cyc_o held until ack. done_o=1, err_o=0, no rd_valid_o.
- Burst read, LINE_WORDS=4, req_adr_i=0x4C, zero-wait slave -> adr_o 0x40,0x44,0x48,0x4C; cti_o 010,010,010,111; rd_idx 0..3 with matching data. cyc_o high exactly 5 cycles.
- Burst with ack_i low for 3 cycles after beat 1 -> adr_o=0x44 and cti_o held during the stall. Four rd_valid_o pulses total.
- err_i on beat 2 -> two rd_valid_o pulses, then err_o=done_o=1, cyc_o=0. TIMEOUT=8 with no ack -> err_o/done_o exactly 8 cycles after stb_o rise.
- rst_i during beat 1 of a burst -> all outputs 0 next edge, no done_o. A req_i pulse while busy_o=1 produces no second cycle.
